// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads and buffers responses for decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_ld,
  input  logic [31:0] pc_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  fetch_ent_t        ent_q [DEPTH];
  fetch_ent_t        head;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [31:0]       pc, pc_nxt, req_pc;
  logic              inflight, squash;
  logic              flush, issue, rsp_take, push, pop;

  assign flush = pc_ld | redirect_valid;
  // Slots already promised to an outstanding request count as occupied.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  // Gated by rst_n so no request is seen while reset is held.
  assign issue = rst_n & ~flush & (occ < (CW+1)'(DEPTH));

  assign rsp_take = imem_rvalid & inflight;
  assign push     = rsp_take & ~squash & ~flush;
  assign pop      = if_valid & id_ready & ~flush;

  assign imem_req  = issue;
  assign imem_addr = pc;

  assign head     = ent_q[rd_ptr];
  assign if_valid = (count != '0);
  assign if_instr = if_valid ? head.instr : '0;
  assign if_pc    = if_valid ? head.pc    : '0;

  always_comb begin
    pc_nxt = pc;
    if (pc_ld)               pc_nxt = pc_data & ~32'h3;
    else if (redirect_valid) pc_nxt = redirect_pc & ~32'h3;
    else if (issue)          pc_nxt = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pc       <= pc_nxt;
      inflight <= issue | (inflight & ~imem_rvalid);
      if (issue) req_pc <= pc;
      // A request still outstanding across a flush must have its data dropped.
      if (flush)         squash <= inflight & ~imem_rvalid;
      else if (rsp_take) squash <= 1'b0;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count  <= count + CW'(push) - CW'(pop);
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)                 perf_fetched <= perf_fetched + 32'd1;
      if (if_valid && !id_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-computed vector table, directed perf/wrap sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0020;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_ld = 1'b0;
  logic [31:0] pc_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_ld(pc_ld), .pc_data(pc_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Instruction memory: answers each request one cycle later with addr ^ KEY.
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = '0;

  // Reference model: a queue of {pc, instr}, the PC and one outstanding request.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_out = 0, m_sq = 0, m_req = 0;
  logic [31:0] m_out_pc = '0;
  int unsigned m_fetched = 0, m_stall = 0;

  task automatic model_reset();
    m_q.delete();
    m_pc = RESET_PC; m_out = 0; m_sq = 0; m_fetched = 0; m_stall = 0;
  endtask

  task automatic model_check();
    bit flush;
    int occ;
    flush = pc_ld | redirect_valid;
    occ = m_q.size() + (m_out ? 1 : 0);
    m_req = !flush && occ < DEPTH;
    chk("m_req", 32'(imem_req), 32'(m_req));
    chk("m_addr", imem_addr, m_pc);
    chk("m_valid", 32'(if_valid), 32'(m_q.size() > 0));
    chk("m_pc", if_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
    chk("m_instr", if_instr, (m_q.size() > 0) ? m_q[0].instr : 32'h0);
  endtask

  task automatic model_update();
    bit flush;
    ent_t e;
    flush = pc_ld | redirect_valid;
    if (m_q.size() > 0 && !id_ready) m_stall++;
    if (flush) m_q.delete();
    else if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
    if (imem_rvalid && m_out) begin
      if (!m_sq && !flush) begin
        e.pc = m_out_pc; e.instr = imem_rdata;
        m_q.push_back(e);
        m_fetched++;
      end
      m_out = 0;
    end
    if (flush) m_sq = m_out;
    if (m_req) begin m_out = 1; m_out_pc = m_pc; m_sq = 0; end
    if (pc_ld)               m_pc = pc_data & ~32'h3;
    else if (redirect_valid) m_pc = redirect_pc & ~32'h3;
    else if (m_req)          m_pc = m_pc + 32'd4;
  endtask

  // Called at a falling edge: apply this cycle's inputs and let them settle.
  task automatic drive(input bit ld, input logic [31:0] ldd, input bit rd, input logic [31:0] rdd,
                       input bit rdy, input bit spur);
    pc_ld = ld; pc_data = ldd; redirect_valid = rd; redirect_pc = rdd; id_ready = rdy;
    imem_rvalid = pend_v | (spur & ~pend_v);
    imem_rdata  = pend_v ? (pend_a ^ KEY) : $urandom;
    #1;
  endtask

  task automatic advance();
    pend_v = imem_req; pend_a = imem_addr;
    model_update();
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input bit keep_pending);
    pc_ld = 0; redirect_valid = 0; id_ready = 0; imem_rvalid = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_stall", perf_stall, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    if (!keep_pending) pend_v = 0;
  endtask

  typedef struct {
    bit rst; bit ld; logic [31:0] ldd; bit rd; logic [31:0] rdd; bit rdy;
    bit e_req; logic [31:0] e_addr; bit e_v; logic [31:0] e_pc;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit rst, input bit ld, input logic [31:0] ldd, input bit rd,
                     input logic [31:0] rdd, input bit rdy, input bit e_req,
                     input logic [31:0] e_addr, input bit e_v, input logic [31:0] e_pc);
    vec_t v;
    v = '{rst, ld, ldd, rd, rdd, rdy, e_req, e_addr, e_v, e_pc};
    vt.push_back(v);
  endtask

  initial begin
    // Stream from reset, then pc_ld mid-stream while a pop and a response are in flight.
    add(1,0,0,0,0,1, 1,32'h400020, 0,0);
    add(0,0,0,0,0,1, 1,32'h400024, 0,0);
    add(0,0,0,0,0,1, 1,32'h400028, 1,32'h400020);
    add(0,0,0,0,0,1, 1,32'h40002c, 1,32'h400024);
    add(0,1,32'h400100,0,0,1, 0,32'h400030, 1,32'h400028);
    add(0,0,0,0,0,1, 1,32'h400100, 0,0);
    add(0,0,0,0,0,1, 1,32'h400104, 0,0);
    add(0,0,0,0,0,1, 1,32'h400108, 1,32'h400100);
    add(0,0,0,0,0,1, 1,32'h40010c, 1,32'h400104);
    // Decode stalled: fill to DEPTH, PC parks at 0x400030, then drain in order.
    add(1,0,0,0,0,0, 1,32'h400020, 0,0);
    add(0,0,0,0,0,0, 1,32'h400024, 0,0);
    add(0,0,0,0,0,0, 1,32'h400028, 1,32'h400020);
    add(0,0,0,0,0,0, 1,32'h40002c, 1,32'h400020);
    add(0,0,0,0,0,0, 0,32'h400030, 1,32'h400020);
    add(0,0,0,0,0,0, 0,32'h400030, 1,32'h400020);
    add(0,0,0,0,0,1, 0,32'h400030, 1,32'h400020);
    add(0,0,0,0,0,1, 1,32'h400030, 1,32'h400024);
    add(0,0,0,0,0,1, 1,32'h400034, 1,32'h400028);
    add(0,0,0,0,0,1, 1,32'h400038, 1,32'h40002c);
    add(0,0,0,0,0,1, 1,32'h40003c, 1,32'h400030);
    add(0,0,0,0,0,1, 1,32'h400040, 1,32'h400034);
    // Redirect coinciding with a response; unaligned target.
    add(1,0,0,0,0,1, 1,32'h400020, 0,0);
    add(0,0,0,1,32'h400203,1, 0,32'h400024, 0,0);
    add(0,0,0,0,0,1, 1,32'h400200, 0,0);
    add(0,0,0,0,0,1, 1,32'h400204, 0,0);
    add(0,0,0,0,0,1, 1,32'h400208, 1,32'h400200);
    // pc_ld beats redirect.
    add(1,0,0,0,0,1, 1,32'h400020, 0,0);
    add(0,1,32'h500000,1,32'h600000,1, 0,32'h400024, 0,0);
    add(0,0,0,0,0,1, 1,32'h500000, 0,0);
    add(0,0,0,0,0,1, 1,32'h500004, 0,0);
    add(0,0,0,0,0,1, 1,32'h500008, 1,32'h500000);
    // PC wraps at the top of the address space.
    add(0,1,32'hFFFF_FFFC,0,0,1, 0,32'h50000c, 1,32'h500004);
    add(0,0,0,0,0,1, 1,32'hFFFF_FFFC, 0,0);
    add(0,0,0,0,0,1, 1,32'h0000_0000, 0,0);
    add(0,0,0,0,0,1, 1,32'h0000_0004, 1,32'hFFFF_FFFC);
    add(0,0,0,0,0,1, 1,32'h0000_0008, 1,32'h0000_0000);

    @(negedge clk);
    foreach (vt[i]) begin
      if (vt[i].rst) do_reset(0);
      drive(vt[i].ld, vt[i].ldd, vt[i].rd, vt[i].rdd, vt[i].rdy, 0);
      chk($sformatf("row%0d req", i), 32'(imem_req), 32'(vt[i].e_req));
      chk($sformatf("row%0d addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(if_valid), 32'(vt[i].e_v));
      chk($sformatf("row%0d pc", i), if_pc, vt[i].e_pc);
      chk($sformatf("row%0d instr", i), if_instr, vt[i].e_v ? (vt[i].e_pc ^ KEY) : 32'h0);
      model_check();
      advance();
    end

    // Ten pushes with three stalled cycles (decode stalls in cycles 2..4).
    do_reset(0);
    for (int c = 0; c < 13; c++) begin
      drive(0, 0, 0, 0, !(c >= 2 && c <= 4), 0);
      model_check();
      advance();
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_stall_3", perf_stall, 32'd3);
`endif

    // Randomized traffic, including spurious responses and mid-stream resets.
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      bit ld, rd, rdy, spur;
      logic [31:0] ldd, rdd;
      if ($urandom_range(0, 199) == 0) do_reset(1);
      ld   = ($urandom_range(0, 99) < 3);
      rd   = ($urandom_range(0, 99) < 4);
      rdy  = ($urandom_range(0, 99) < 70);
      spur = ($urandom_range(0, 99) < 5);
      ldd  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdd  = $urandom;
      drive(ld, ldd, rd, rdd, rdy, spur);
      model_check();
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
`endif
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
